axis_tens_tx: RTL and testbench
===============================

Name: axis_tens_tx

Overview:
- Transmit end of the design's outbound AXI4-Stream master port. It is the counterpart of the external sink that consumes M_AXIS with random back-pressure.
- Accepts whole result data vectors (VECT_SIZE words) from the processing pipeline output, one vector per handshake.
- Serializes each vector into TDATA_WDT-wide beats and asserts TLAST on the final beat of a tensor transfer whose vector count is programmed at start.
- Sits between the pipeline output stage and the top-level M_AXIS_* pins.

Parameters:
- WORD_WDT, 16, width of one data word in bits.
- VECT_SIZE, 8, words per input vector.
- TDATA_WDT, 64, AXIS data width. VECT_SIZE*WORD_WDT must be an integer multiple of TDATA_WDT, and TDATA_WDT must be a multiple of 8.
- CNT_WDT, 16, width of the vector-count field.
- Derived: BEATS = VECT_SIZE*WORD_WDT/TDATA_WDT (default 2). KEEP_WDT = TDATA_WDT/8.

Ports:
- clk, in, 1, clock; all logic is on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, single-cycle pulse that begins a transfer; ignored while busy=1.
- vect_cnt, in, CNT_WDT, number of vectors in the transfer; sampled only when start is accepted.
- busy, out, 1, high from the accepted start until the final beat is accepted.
- done, out, 1, one-cycle pulse when the transfer completes.
- in_data, in, VECT_SIZE*WORD_WDT, input vector; word 0 in the LSBs.
- in_val, in, 1, input vector valid.
- in_rdy, out, 1, input vector ready.
- M_AXIS_TDATA, out, TDATA_WDT, stream data.
- M_AXIS_TKEEP, out, KEEP_WDT, byte enables; always all-ones.
- M_AXIS_TLAST, out, 1, last beat of the transfer.
- M_AXIS_TVALID, out, 1, stream valid.
- M_AXIS_TREADY, in, 1, stream ready from the sink.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Next cycle: busy=0, done=0, in_rdy=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TKEEP=all-ones.
  - All counters and the hold register clear.
  - Reset asserted mid-transfer drops any in-flight data with no TLAST and no done pulse.
- FSM states IDLE, RUN, FIN.
  - IDLE: start=1 and vect_cnt!=0 → RUN; latch vect_cnt into rem_in and rem_out; busy=1 from the next cycle.
  - IDLE: start=1 and vect_cnt==0 → FIN directly; no beats are emitted.
  - RUN → FIN on the cycle the final beat handshakes (TVALID & TREADY & TLAST).
  - FIN: done=1 for exactly one cycle, busy=0, then → IDLE. A start during FIN is ignored.
- Hold register: one vector plus hold_val flag and beat index beat_idx (0..BEATS-1).
  - M_AXIS_TVALID = hold_val.
  - M_AXIS_TDATA = bits [beat_idx*TDATA_WDT +: TDATA_WDT] of the held vector; beat 0 is sent first.
  - M_AXIS_TLAST = hold_val & (beat_idx==BEATS-1) & (rem_out==1).
- Beat handshake (TVALID & TREADY): beat_idx increments. On the last beat of a vector, beat_idx wraps to 0 and rem_out decrements.
- in_rdy = (state==RUN) & (rem_in!=0) & (~hold_val | last-beat handshake this cycle).
  - in_rdy is combinational from M_AXIS_TREADY, which allows back-to-back vectors with no bubble.
  - On an input handshake: load the hold register, set hold_val=1, decrement rem_in.
- Last beat handshakes with no new vector loaded → hold_val=0 next cycle.
- AXIS stability: while TVALID=1 and TREADY=0, TDATA, TLAST and TKEEP stay constant; TVALID never drops without a handshake (except on reset).
- Sustained throughput: 1 beat/cycle with TREADY held high and in_val supplied. First-beat latency is 1 cycle after the input handshake.
- in_val=1 outside RUN, or after all vect_cnt vectors have been accepted: in_rdy stays 0 and the input is not consumed.
- vect_cnt = 2^CNT_WDT-1 must work without counter overflow.

Test Plan:
- VECT_SIZE=8, WORD_WDT=16, TDATA_WDT=64, vect_cnt=3, TREADY=1, vectors with words 0..23 → exactly 6 beats; beat0 TDATA=0x0003_0002_0001_0000; TLAST only on beat 6; done pulses 2 cycles after the last handshake; busy low in the same cycle as done.
- Same vectors, TREADY random with probability 4/7 and in_val random → identical 6-beat sequence; TDATA/TLAST held stable whenever TVALID=1 and TREADY=0; in_rdy never high while hold_val=1 without a last-beat handshake.
- vect_cnt=0, start pulse → no TVALID; done pulses exactly 2 cycles after start; in_rdy stays 0.
- rst asserted after 3 of 6 beats → next cycle TVALID=0, busy=0, no done; new start with vect_cnt=1 → 2 beats, TLAST on beat 2.
- start re-pulsed during RUN with vect_cnt=5 → ignored; original transfer of 3 vectors completes with exactly 6 beats.
- in_val=1 held before start and after completion → in_rdy=0; no extra beats; exactly 3 vectors consumed.

Source files
------------

// File: rtl/axis_tens_tx.sv
// AXI4-Stream transmit stage: takes whole result vectors from the pipeline and
// serializes them into TDATA_WDT-wide beats, with TLAST closing a tensor of vect_cnt vectors.
module axis_tens_tx #(
  parameter int WORD_WDT  = 16,
  parameter int VECT_SIZE = 8,
  parameter int TDATA_WDT = 64,
  parameter int CNT_WDT   = 16,
  localparam int VEC_WDT  = VECT_SIZE * WORD_WDT,
  localparam int KEEP_WDT = TDATA_WDT / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WDT-1:0]   vect_cnt,
  output logic                 busy,
  output logic                 done,
  input  logic [VEC_WDT-1:0]   in_data,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic [TDATA_WDT-1:0] M_AXIS_TDATA,
  output logic [KEEP_WDT-1:0]  M_AXIS_TKEEP,
  output logic                 M_AXIS_TLAST,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic [1:0]           state_dbg
);

  localparam int BEATS  = VEC_WDT / TDATA_WDT;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BEATS - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // The stream side never drops valid or changes data/last while waiting for ready.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [CNT_WDT-1:0]  rem_in, rem_out;
  logic [VEC_WDT-1:0]  hold_vec;
  logic                hold_val;
  logic [BIDX_W-1:0]   beat_idx;
  logic                done_q;
  logic                beat_hs, vec_end_hs, in_hs;

  assign beat_hs    = hold_val & M_AXIS_TREADY;
  assign vec_end_hs = beat_hs & (beat_idx == LAST_IDX);
  // Ready looks through the current last beat so vectors stream with no bubble.
  assign in_rdy     = (state == RUN) & (rem_in != '0) & (~hold_val | vec_end_hs);
  assign in_hs      = in_val & in_rdy;

  assign M_AXIS_TVALID = hold_val;
  assign M_AXIS_TDATA  = hold_vec[beat_idx*TDATA_WDT +: TDATA_WDT];
  assign M_AXIS_TKEEP  = '1;
  assign M_AXIS_TLAST  = hold_val & (beat_idx == LAST_IDX) & (rem_out == CNT_WDT'(1));

  assign busy      = (state == RUN);
  assign done      = done_q;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (vect_cnt != '0) ? RUN : FIN;
      RUN:  if (vec_end_hs && rem_out == CNT_WDT'(1)) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem_in   <= '0;
      rem_out  <= '0;
      hold_vec <= '0;
      hold_val <= 1'b0;
      beat_idx <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == FIN);
      if (state == IDLE && start && vect_cnt != '0) begin
        rem_in  <= vect_cnt;
        rem_out <= vect_cnt;
      end
      if (beat_hs)
        beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
      if (vec_end_hs)
        rem_out <= rem_out - 1'b1;
      if (in_hs) begin
        hold_vec <= in_data;
        hold_val <= 1'b1;
        rem_in   <= rem_in - 1'b1;
      end else if (vec_end_hs) begin
        hold_val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_tens_tx.sv
// Directed bench for axis_tens_tx: vectors of consecutive 16-bit words, beat scoreboard,
// AXIS stability and in_rdy gating monitor, done/busy timing checks.
module tb_axis_tens_tx;

  localparam int WORD_WDT = 16, VECT_SIZE = 8, TDATA_WDT = 64, CNT_WDT = 16;
  localparam int BEATS = VECT_SIZE * WORD_WDT / TDATA_WDT;

  logic                          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [CNT_WDT-1:0]            vect_cnt = '0;
  logic                          busy, done, in_rdy, in_val = 1'b0;
  logic [VECT_SIZE*WORD_WDT-1:0] in_data = '0;
  logic [TDATA_WDT-1:0]          tdata;
  logic [TDATA_WDT/8-1:0]        tkeep;
  logic                          tlast, tvalid, tready = 1'b1;
  logic [1:0]                    state_dbg;

  axis_tens_tx #(.WORD_WDT(WORD_WDT), .VECT_SIZE(VECT_SIZE), .TDATA_WDT(TDATA_WDT), .CNT_WDT(CNT_WDT)) dut (
    .clk(clk), .rst(rst), .start(start), .vect_cnt(vect_cnt), .busy(busy), .done(done),
    .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
    .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep), .M_AXIS_TLAST(tlast),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0, n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard
  logic [TDATA_WDT-1:0] exp_q[$];
  logic                 exp_last_q[$];
  int beats, dones, consumed, tvalid_seen, rdy_seen;
  int done_cyc, last_cyc, start_cyc;
  logic busy_at_done;
  logic [TDATA_WDT-1:0] first_data, prev_data;
  logic prev_stall = 1'b0, prev_last;
  bit tready_rnd = 0, abort = 0;

  function automatic logic [TDATA_WDT-1:0] exp_beat(input int v, input int b);
    int w0;
    w0 = v * 8 + b * 4;
    return {16'(w0 + 3), 16'(w0 + 2), 16'(w0 + 1), 16'(w0)};
  endfunction

  function automatic logic [VECT_SIZE*WORD_WDT-1:0] vec(input int i);
    logic [VECT_SIZE*WORD_WDT-1:0] v;
    for (int w = 0; w < VECT_SIZE; w++) v[w*WORD_WDT +: WORD_WDT] = 16'(i * VECT_SIZE + w);
    return v;
  endfunction

  task automatic setup_xfer(input int n);
    exp_q.delete();
    exp_last_q.delete();
    for (int v = 0; v < n; v++)
      for (int b = 0; b < BEATS; b++) begin
        exp_q.push_back(exp_beat(v, b));
        exp_last_q.push_back(v == n - 1 && b == BEATS - 1);
      end
    beats = 0; dones = 0; consumed = 0; tvalid_seen = 0; rdy_seen = 0;
    done_cyc = -100; last_cyc = -1000;
  endtask

  // monitor: mid-cycle sampling
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tvalid_hold", tvalid, 1'b1);
        check("tdata_hold", tdata, prev_data);
        check("tlast_hold", tlast, prev_last);
      end
      if (!busy) check("in_rdy_idle", in_rdy, 1'b0);
      else if (tvalid && !(tready && (beats % BEATS == BEATS - 1))) check("in_rdy_gate", in_rdy, 1'b0);
      if (tvalid) tvalid_seen++;
      if (in_rdy) rdy_seen++;
      if (in_val && in_rdy) consumed++;
      if (tvalid && tready) begin
        if (beats == 0) first_data = tdata;
        check("tkeep", tkeep, 8'hff);
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          check("tdata", tdata, exp_q.pop_front());
          check("tlast", tlast, exp_last_q.pop_front());
        end
        if (tlast) last_cyc = cyc;
        beats++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  always begin
    @(posedge clk);
    #1;
    tready = tready_rnd ? ($urandom_range(0, 6) < 4) : 1'b1;
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    vect_cnt = CNT_WDT'(n);
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drive_vectors(input int n, input bit rnd, input bit keep);
    int i = 0, g = 0;
    bit hs;
    while (i < n && g < 2000 && !abort) begin
      in_data = vec(i);
      in_val  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      hs = in_val && in_rdy;
      @(posedge clk);
      #1;
      if (hs) i++;
      g++;
    end
    if (g >= 2000) check("drv_timeout", 0, 1);
    in_val = keep;
  endtask

  task automatic wait_done(input int limit);
    int g;
    for (g = 0; g < limit; g++) begin
      if (dones > 0) break;
      @(posedge clk);
      #1;
    end
    if (g >= limit) check("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic post_checks(input string t, input int n);
    check({t, "_beats"}, beats, n * BEATS);
    check({t, "_exp_left"}, exp_q.size(), 0);
    check({t, "_dones"}, dones, 1);
    check({t, "_consumed"}, consumed, n);
    check({t, "_done_lat"}, done_cyc - last_cyc, 2);
    check({t, "_busy_at_done"}, busy_at_done, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tkeep", tkeep, 8'hff);

    // three vectors, sink always ready
    setup_xfer(3);
    do_start(3);
    check("busy_after_start", busy, 1);
    drive_vectors(3, 0, 0);
    wait_done(200);
    post_checks("full_rate", 3);
    check("beat0_data", first_data, 64'h0003_0002_0001_0000);

    // random back-pressure and input valid
    setup_xfer(3);
    tready_rnd = 1;
    do_start(3);
    drive_vectors(3, 1, 0);
    wait_done(400);
    post_checks("random", 3);
    tready_rnd = 0;

    // zero-length transfer with input offered
    setup_xfer(0);
    in_data = vec(0);
    in_val = 1'b1;
    do_start(0);
    wait_done(20);
    in_val = 1'b0;
    check("zero_dones", dones, 1);
    check("zero_done_lat", done_cyc - start_cyc, 2);
    check("zero_tvalid", tvalid_seen, 0);
    check("zero_rdy", rdy_seen, 0);
    check("zero_consumed", consumed, 0);

    // reset in the middle of a transfer
    setup_xfer(3);
    do_start(3);
    fork
      drive_vectors(3, 0, 0);
      begin
        for (int g = 0; g < 100 && beats < 3; g++) begin
          @(posedge clk);
          #1;
        end
        abort = 1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_tvalid", tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tlast", tlast, 0);
      end
    join
    abort = 0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_done", dones, 0);
    setup_xfer(1);
    do_start(1);
    drive_vectors(1, 0, 0);
    wait_done(50);
    post_checks("after_rst", 1);

    // start re-pulsed while running is ignored
    setup_xfer(3);
    do_start(3);
    fork
      drive_vectors(3, 1, 0);
      begin
        repeat (2) @(posedge clk);
        #1;
        check("restart_busy", busy, 1);
        start = 1'b1;
        vect_cnt = 16'd5;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    wait_done(200);
    post_checks("restart", 3);

    // input valid held before start and after completion
    setup_xfer(3);
    in_data = vec(0);
    in_val = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("held_pre_consumed", consumed, 0);
    do_start(3);
    drive_vectors(3, 0, 1);
    wait_done(200);
    repeat (8) @(posedge clk);
    #1;
    in_val = 1'b0;
    post_checks("held", 3);

    // large count latches without overflow: first vector closes no tensor
    setup_xfer(0);
    exp_q.push_back(exp_beat(0, 0));
    exp_last_q.push_back(1'b0);
    exp_q.push_back(exp_beat(0, 1));
    exp_last_q.push_back(1'b0);
    do_start(16'hffff);
    drive_vectors(1, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("maxcnt_beats", beats, 2);
    check("maxcnt_busy", busy, 1);
    check("maxcnt_dones", dones, 0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
